// File: rtl/bpred_resolve_queue.sv
// rtl/bpred_resolve_queue.sv - in-order branch resolve queue with BHT update and mispredict flush
// Fetch pushes predicted branches; execute resolves the oldest and may squash all younger ones.
module bpred_resolve_queue #(
   parameter int DEPTH = 4,
   localparam int PTRW = $clog2(DEPTH)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_push_valid,
   output logic            o_push_ready,
   input  logic [31:0]     i_push_pc,
   input  logic            i_push_pred,
   input  logic [31:0]     i_push_target,
   input  logic            i_res_valid,
   output logic            o_res_ready,
   input  logic            i_res_taken,
   output logic            o_update_en,
   output logic [31:0]     o_update_addr,
   output logic            o_update_taken,
   output logic            o_mispredict,
   output logic [31:0]     o_redirect_pc,
   output logic [PTRW:0]   o_count
);

   localparam logic [PTRW:0]   FULL_COUNT = (PTRW+1)'(DEPTH);
   localparam logic [PTRW:0]   CNT_ONE    = (PTRW+1)'(1);
   localparam logic [PTRW-1:0] PTR_ONE    = PTRW'(1);

   logic [31:0]     pc_mem   [DEPTH];
   logic            pred_mem [DEPTH];
   logic [31:0]     tgt_mem  [DEPTH];

   logic [PTRW-1:0] head;
   logic [PTRW-1:0] tail;
   logic [PTRW:0]   count;

   logic            full;
   logic            empty;
   logic            push_fire;
   logic            res_fire;
   logic            mis;
   logic [31:0]     head_pc;
   logic [31:0]     head_tgt;
   logic            head_pred;

   assign full         = (count == FULL_COUNT);
   assign empty        = (count == '0);
   assign o_push_ready = !full;
   assign o_res_ready  = !empty;
   assign o_count      = count;

   assign push_fire = i_push_valid && o_push_ready;
   assign res_fire  = i_res_valid && o_res_ready;

   assign head_pc   = pc_mem[head];
   assign head_tgt  = tgt_mem[head];
   assign head_pred = pred_mem[head];
   assign mis       = res_fire && (i_res_taken != head_pred);

   // Payload needs no reset; a write during a mispredict lands in a slot the flush already abandons.
   always_ff @(posedge i_clk) begin
      if (push_fire) begin
         pc_mem[tail]   <= i_push_pc;
         pred_mem[tail] <= i_push_pred;
         tgt_mem[tail]  <= i_push_target;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         o_update_en    <= 1'b0;
         o_update_addr  <= '0;
         o_update_taken <= 1'b0;
         o_mispredict   <= 1'b0;
         o_redirect_pc  <= '0;
      end else begin
         if (mis) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push_fire) tail <= tail + PTR_ONE;
            if (res_fire)  head <= head + PTR_ONE;
            case ({push_fire, res_fire})
               2'b10:   count <= count + CNT_ONE;
               2'b01:   count <= count - CNT_ONE;
               default: count <= count;
            endcase
         end

         o_update_en  <= res_fire;
         o_mispredict <= mis;
         if (res_fire) begin
            o_update_addr  <= head_pc;
            o_update_taken <= i_res_taken;
         end
         if (mis) begin
            o_redirect_pc <= i_res_taken ? head_tgt : head_pc + 32'd4;
         end
      end
   end

endmodule
